// File: rtl/div_43s_18s_seq.sv
// Sequential signed divider: restoring radix-2, one quotient bit per cycle.
// Recovers the 25-bit multiplicand from a 43-bit product and its 18-bit multiplier.
module div_43s_18s_seq #(
  parameter int NW = 43,
  parameter int DW = 18,
  parameter int QW = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] N,
  input  logic [DW-1:0] D,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] Q,
  output logic [DW-1:0] R,
  output logic          ovf,
  output logic          div0,
  output logic [1:0]    dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready/out_valid are decoded from state only, never from the inputs.
  localparam int CW = $clog2(NW);
  localparam logic [NW-1:0] QLIM = NW'(1) << (QW - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic [NW-1:0] nm;      // dividend magnitude, replaced by quotient bits as it shifts
  logic [DW:0]   dm;
  logic [DW-1:0] rem;
  logic          sn, sd;

  logic [DW:0]   rem_sh;
  logic          ge;
  logic [DW-1:0] rem_nx;
  logic          neg, ovf_c;
  logic [QW-1:0] q_c;
  logic [DW-1:0] r_c;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid)         state_nx = CALC;
      CALC: if (cnt == '0)        state_nx = FIX;
      FIX:                        state_nx = DONE;
      DONE: if (out_ready)        state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_comb begin
    rem_sh = {rem, nm[NW-1]};
    ge     = (rem_sh >= dm);
    rem_nx = ge ? DW'(rem_sh - dm) : rem_sh[DW-1:0];
  end

  // Negative quotients may reach -2^(QW-1); positive ones stop one short.
  always_comb begin
    neg   = sn ^ sd;
    ovf_c = neg ? (nm > QLIM) : (nm >= QLIM);
    q_c   = neg ? -nm[QW-1:0] : nm[QW-1:0];
    if (ovf_c) q_c = neg ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}};
    r_c   = sn ? -rem : rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      nm   <= '0;
      dm   <= '0;
      rem  <= '0;
      sn   <= 1'b0;
      sd   <= 1'b0;
      Q    <= '0;
      R    <= '0;
      ovf  <= 1'b0;
      div0 <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sn  <= N[NW-1];
          sd  <= D[DW-1];
          nm  <= N[NW-1] ? -N : N;
          dm  <= D[DW-1] ? -{D[DW-1], D} : {1'b0, D};
          rem <= '0;
          cnt <= CW'(NW - 1);
        end
        CALC: begin
          rem <= rem_nx;
          nm  <= {nm[NW-2:0], ge};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          // A zero divisor still ran the full loop; its garbage is discarded here.
          if (dm == '0) begin
            Q    <= '0;
            R    <= '0;
            ovf  <= 1'b0;
            div0 <= 1'b1;
          end else begin
            Q    <= q_c;
            R    <= r_c;
            ovf  <= ovf_c;
            div0 <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_43s_18s_seq.sv
// Scoreboard bench for div_43s_18s_seq: directed signed/overflow/div0 cases,
// backpressure, mid-operation reset and a short random sweep.
module tb_div_43s_18s_seq;
  localparam int NW = 43;
  localparam int DW = 18;
  localparam int QW = 25;
  localparam int W  = QW + DW + 2;
  localparam int LAT = NW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NW-1:0] N = '0;
  logic [DW-1:0] D = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [QW-1:0] Q;
  logic [DW-1:0] R;
  logic          ovf;
  logic          div0;
  logic [1:0]    dbg_state;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int ka  = 0;

  div_43s_18s_seq #(.NW(NW), .DW(DW), .QW(QW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .N(N), .D(D), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .R(R), .ovf(ovf), .div0(div0), .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input longint n, input longint d);
    longint q, r;
    logic [63:0] qb, rb;
    logic o;
    if (d == 0) return {{QW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b1};
    q = n / d;
    r = n % d;
    o = (q > 64'sd16777215) || (q < -64'sd16777216);
    if (o) q = (q > 0) ? 64'sd16777215 : -64'sd16777216;
    qb = q;
    rb = r;
    return {qb[QW-1:0], rb[DW-1:0], o, 1'b0};
  endfunction

  // driver
  task automatic send(input longint n, input longint d);
    int g = 0;
    logic [63:0] nb, db;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1; g++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    nb = n;
    db = d;
    N = nb[NW-1:0];
    D = db[DW-1:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    ka = cyc;
    in_valid = 1'b0;
    exp_q.push_back(model(n, d));
  endtask

  // wait for a result, check latency and fields; optionally check the 1-cycle pulse
  task automatic collect(input bit check_pulse);
    int g = 0;
    logic [W-1:0] e;
    do begin
      @(negedge clk); g++;
    end while (!out_valid && g < 100);
    if (!out_valid) begin
      chk("out_valid_timeout", 64'(out_valid), 64'd1);
      return;
    end
    chk("latency", 64'(cyc - ka), 64'(LAT));
    if (exp_q.size() == 0) begin
      chk("unexpected_output", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("Q", 64'(Q), 64'(e[W-1 -: QW]));
    chk("R", 64'(R), 64'(e[DW+1:2]));
    chk("ovf", 64'(ovf), 64'(e[1]));
    chk("div0", 64'(div0), 64'(e[0]));
    if (check_pulse) begin
      @(negedge clk);
      chk("pulse_len", 64'(out_valid), 64'd0);
    end
  endtask

  function automatic longint rnd_n();
    longint n;
    n = longint'({$urandom, $urandom});
    n = (n <<< 21) >>> 21;
    if ($urandom_range(0, 1) == 1) n = n >>> 18;
    return n;
  endfunction

  function automatic longint rnd_d();
    longint d;
    d = longint'($urandom_range(0, 262143));
    if (d >= 131072) d = d - 262144;
    return d;
  endfunction

  initial begin
    logic [W-1:0] snap;
    int hits;
    #12;
    chk("rst_Q", 64'(Q), 64'd0);
    chk("rst_R", 64'(R), 64'd0);
    chk("rst_flags", 64'({ovf, div0, out_valid}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    send(1000, 7);                collect(1);
    send(-1000, 7);               collect(1);
    send(1000, -7);               collect(1);
    send(-1000, -7);              collect(1);
    send(longint'(1) << 41, -131072); collect(1);
    send(-16777216, 1);           collect(1);
    send(longint'(1) << 30, 1);   collect(1);
    send(-(longint'(1) << 42), -1); collect(1);
    send(-(longint'(1) << 30), 1);  collect(1);
    send(12345, 0);               collect(1);
    send(-131072, -131072);       collect(1);

    for (int i = 0; i < 8; i++) begin
      send(rnd_n(), rnd_d());
      collect(1);
    end

    // backpressure: results held, no accept while DONE
    out_ready = 1'b0;
    send(5000000, -333);
    collect(0);
    snap = {Q, R, ovf, div0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      N = NW'(rnd_n());
      D = DW'(rnd_d());
      @(negedge clk);
      chk("bp_hold", 64'({Q, R, ovf, div0}), 64'(snap));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    N = NW'(777777);
    D = DW'(-55);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_idle", 64'({in_ready, out_valid}), 64'b10);
    chk("idle_hold", 64'({Q, R, ovf, div0}), 64'(snap));
    @(posedge clk); #1;
    ka = cyc;
    in_valid = 1'b0;
    exp_q.push_back(model(777777, -55));
    collect(1);

    // asynchronous reset in the middle of CALC
    send(-999999, 321);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_outputs", 64'({Q, R, ovf, div0, out_valid}), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    hits = 0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk("aborted_no_output", 64'(hits), 64'd0);
    send(1000, 7);
    collect(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
